// File: rtl/fir_mac_sequencer_pkg.sv
// Shared constants for the FIR MAC sequencer: FSM encoding, width/tap bounds
// and the coefficient values loaded at reset.
package fir_mac_sequencer_pkg;

  localparam int W_DEF     = 8;
  localparam int NTAPS_DEF = 3;
  localparam int NTAPS_MIN = 2;
  localparam int NTAPS_MAX = 4;
  localparam int IDX_W     = $clog2(NTAPS_MAX);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic signed [7:0] B0_DEF = 8'sh01;
  localparam logic signed [7:0] B1_DEF = 8'sh02;
  localparam logic signed [7:0] B2_DEF = 8'shFD;
  localparam logic signed [7:0] B3_DEF = 8'sh00;

  function automatic logic signed [7:0] coef_def(input int k);
    case (k)
      0:       return B0_DEF;
      1:       return B1_DEF;
      2:       return B2_DEF;
      default: return B3_DEF;
    endcase
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_unit.sv
// Shared multiply-accumulate datapath: one tap per use, everything modulo 2^W.
module fir_mac_unit
  import fir_mac_sequencer_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] coef,
  input  logic [W-1:0] samp,
  output logic [W-1:0] sum
);

  // Low W bits of the product are identical for signed and unsigned operands.
  assign sum = acc + W'(coef * samp);

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequential FIR filter: one shared MAC walks the taps, then holds the result
// until the consumer takes it. Coefficients are writable only while idle.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int W     = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  output logic         cfg_ready,
  output logic         busy
);

  if (NTAPS < NTAPS_MIN || NTAPS > NTAPS_MAX) begin : g_ntaps_range_check
    $error("fir_mac_sequencer: NTAPS out of supported range");
  end

  logic [1:0]                state;
  logic [IDX_W-1:0]          idx;
  logic [W-1:0]              acc, acc_nxt, coef_sel, samp_sel;
  logic [NTAPS-1:0][W-1:0]   hist, coef;
  logic                      last_tap;

  assign in_ready  = (state == ST_IDLE);
  assign cfg_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);
  assign last_tap  = (idx == IDX_W'(NTAPS - 1));

  // hist[k] holds x[n-k]; select the tap pair for the current index.
  always_comb begin
    coef_sel = '0;
    samp_sel = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (idx == IDX_W'(k)) begin
        coef_sel = coef[k];
        samp_sel = hist[k];
      end
    end
  end

  fir_mac_unit #(.W(W)) u_mac (
    .acc  (acc),
    .coef (coef_sel),
    .samp (samp_sel),
    .sum  (acc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      idx      <= '0;
      hist     <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          state <= ST_MAC;
          acc   <= '0;
          idx   <= '0;
          hist  <= {hist[NTAPS-2:0], in_data};
        end
        ST_MAC: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if (last_tap) begin
            state    <= ST_OUT;
            out_data <= acc_nxt;
          end
        end
        ST_OUT: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writes land only in IDLE, so a sample accepted on the same edge sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= W'(coef_def(k));
    end else if (cfg_we && state == ST_IDLE) begin
      for (int k = 0; k < NTAPS; k++)
        if (cfg_addr == 2'(k)) coef[k] <= cfg_data;
    end
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 3, number of filter taps (2..4).
REQ-002 SHALL have parameter W, default 8, sample, coefficient and result width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input sample offered.
REQ-006 SHALL have port in_ready  output  1  sequencer accepts a sample.
REQ-007 SHALL have port in_data  input  W  sample x[n], two's complement.
REQ-008 SHALL have port out_valid  output  1  result y[n] available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_data  output  W  result y[n], two's complement.
REQ-011 SHALL have port cfg_we  input  1  coefficient write strobe.
REQ-012 SHALL have port cfg_addr  input  2  coefficient index k (b_k).
REQ-013 SHALL have port cfg_data  input  W  coefficient value, two's complement.
REQ-014 SHALL have port cfg_ready  output  1  coefficient write accepted this cycle.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL compute y[n] = sum over k=0..NTAPS-1 of b_k*x[n-k] using one shared multiply-accumulate, one tap per cycle.
REQ-017 SHALL implement states IDLE, MAC, OUT; IDLE->MAC on in_valid&in_ready; MAC->OUT after NTAPS MAC cycles; OUT->IDLE on out_valid&out_ready.
REQ-018 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in OUT; cfg_ready=1 only in IDLE.
REQ-019 On input acceptance, SHALL shift history (x[n]<=in_data, x[n-k]<=x[n-k+1]), clear accumulator, set tap index to 0.
REQ-020 In MAC, SHALL update acc <= acc + b_idx*x[n-idx], idx incrementing 0..NTAPS-1.
REQ-021 Products and sums SHALL be truncated to low W bits (modulo 2^W); no saturation, no overflow flag.
REQ-022 out_valid SHALL rise NTAPS cycles after the accepting edge; out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 Throughput SHALL be one sample per NTAPS+2 cycles with out_ready tied high.
REQ-024 cfg_we&cfg_ready SHALL write cfg_data to b_cfg_addr at that edge; writes with cfg_addr>=NTAPS SHALL be ignored.
REQ-025 cfg_we while cfg_ready=0 SHALL be ignored (not deferred); coefficients SHALL never change during MAC/OUT.
REQ-026 cfg_we and in_valid on the same IDLE edge SHALL both take effect; the accepted sample SHALL use the newly written coefficient.
REQ-027 in_valid while in_ready=0 SHALL not alter history; the sample remains offered until accepted.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, acc=0, idx=0, history=0, out_data=0, out_valid=0.
REQ-029 rst SHALL load coefficients b0=8'h01, b1=8'h02, b2=8'hFD (+1,+2,-3), b3=8'h00.
REQ-030 rst asserted mid-MAC or in OUT SHALL discard the in-flight result; no out_valid pulse after release.
REQ-031 After rst release, in_ready=1 and cfg_ready=1 on the first cycle.

Structure
REQ-032 Shared package SHALL hold state encoding, W, NTAPS bounds and default coefficient constants.
REQ-033 SHALL instantiate one sub-module fir_mac_unit (W x W multiply, truncated add; combinational).

Verification
REQ-034 After reset, x=1,2,3 (out_ready=1) -> y=1, 4, 4.
REQ-035 After reset, x=100,100 -> y=100, then 44 (8'h2C, 300 mod 256).
REQ-036 out_ready=0 for 5 cycles in OUT -> out_valid and out_data held, in_ready=0, later sample not accepted.
REQ-037 After reset, write b0=3 in IDLE then x=5 -> y=15; cfg_we during MAC -> cfg_ready=0, coefficient unchanged.
REQ-038 rst pulse in 2nd MAC cycle -> out_valid stays 0, history zero, next x=7 -> y=7.
REQ-039 cfg_addr=3 with NTAPS=3 -> no effect; x=1,2,3 still gives 1, 4, 4.
